// File: rtl/wb_stage_q.sv
// Write-back retire queue: buffers MEM-stage results, drains them in order to the
// register-file write port, and answers decode-stage hazard/forwarding queries.
module wb_stage_q #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     ms_to_ws_valid,
    input  logic                     ms_gr_we,
    input  logic [ADDR_W-1:0]        ms_dest,
    input  logic [DATA_W-1:0]        ms_result,
    input  logic [31:0]              ms_pc,
    output logic                     ws_allowin,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic                     rf_wready,
    input  logic [ADDR_W-1:0]        q0_addr,
    input  logic [ADDR_W-1:0]        q1_addr,
    output logic                     q0_hit,
    output logic                     q1_hit,
    output logic [DATA_W-1:0]        q0_data,
    output logic [DATA_W-1:0]        q1_data,
    output logic [$clog2(DEPTH):0]   ws_count,
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_wen,
    output logic [ADDR_W-1:0]        debug_wb_rf_wnum,
    output logic [DATA_W-1:0]        debug_wb_rf_wdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              gr_we;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] result;
        logic [31:0]       pc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    entry_t             head_e;
    logic               head_valid;
    logic               accept;
    logic               retire;
    logic [PTR_W-1:0]   q_idx;

    // Head view and handshake terms; allowin depends on registered occupancy only
    assign head_e     = mem_q[head_q];
    assign head_valid = valid_q[head_q];
    assign ws_allowin = (count_q < CNT_W'(DEPTH));
    assign accept     = ms_to_ws_valid && ws_allowin;
    assign retire     = head_valid && (!head_e.gr_we || rf_wready);

    assign rf_we    = head_valid && head_e.gr_we;
    assign rf_waddr = head_e.dest;
    assign rf_wdata = head_e.result;
    assign ws_count = count_q;

    assign debug_wb_pc       = head_e.pc;
    assign debug_wb_rf_wen   = {4{rf_we && rf_wready}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    // Next-state for pointers, occupancy, valid bits and payload
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (accept) begin
            mem_d[tail_q]   = '{gr_we: ms_gr_we, dest: ms_dest, result: ms_result, pc: ms_pc};
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({accept, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared asynchronously
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; qualified by valid bits so it needs no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match wins
    always_comb begin
        q0_hit  = 1'b0;
        q1_hit  = 1'b0;
        q0_data = '0;
        q1_data = '0;
        q_idx   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            q_idx = head_q + PTR_W'(i);
            if (valid_q[q_idx] && mem_q[q_idx].gr_we && (q0_addr != '0) && (mem_q[q_idx].dest == q0_addr)) begin
                q0_hit  = 1'b1;
                q0_data = mem_q[q_idx].result;
            end
            if (valid_q[q_idx] && mem_q[q_idx].gr_we && (q1_addr != '0) && (mem_q[q_idx].dest == q1_addr)) begin
                q1_hit  = 1'b1;
                q1_data = mem_q[q_idx].result;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_q.sv
// Self-checking bench for wb_stage_q against a queue-based reference model.
module tb_wb_stage_q;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ms_to_ws_valid;
    logic          ms_gr_we;
    logic [AW-1:0] ms_dest;
    logic [DW-1:0] ms_result;
    logic [31:0]   ms_pc;
    logic          ws_allowin;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_wready;
    logic [AW-1:0] q0_addr, q1_addr;
    logic          q0_hit, q1_hit;
    logic [DW-1:0] q0_data, q1_data;
    logic [CW-1:0] ws_count;
    logic [31:0]   debug_wb_pc;
    logic [3:0]    debug_wb_rf_wen;
    logic [AW-1:0] debug_wb_rf_wnum;
    logic [DW-1:0] debug_wb_rf_wdata;

    wb_stage_q #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .resetn(resetn),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
        .ms_result(ms_result), .ms_pc(ms_pc), .ws_allowin(ws_allowin),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wready(rf_wready),
        .q0_addr(q0_addr), .q1_addr(q1_addr), .q0_hit(q0_hit), .q1_hit(q1_hit),
        .q0_data(q0_data), .q1_data(q1_data), .ws_count(ws_count),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] dest;
        logic [DW-1:0] res;
        logic [31:0]   pc;
    } ent_t;

    ent_t mq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against what the model queue implies
    task automatic check_outputs();
        int            n;
        logic          exp_we;
        logic          h0, h1;
        logic [DW-1:0] d0, d1;
        n      = mq.size();
        exp_we = 1'b0;
        if (n > 0) exp_we = mq[0].we;
        chk("ws_count", 64'(ws_count), 64'(n));
        chk("ws_allowin", 64'(ws_allowin), 64'(n < D));
        chk("rf_we", 64'(rf_we), 64'(exp_we));
        chk("debug_wen", 64'(debug_wb_rf_wen), 64'({4{exp_we && rf_wready}}));
        if (n > 0) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(mq[0].dest));
            chk("rf_wdata", 64'(rf_wdata), 64'(mq[0].res));
            chk("debug_pc", 64'(debug_wb_pc), 64'(mq[0].pc));
            chk("debug_wnum", 64'(debug_wb_rf_wnum), 64'(mq[0].dest));
            chk("debug_wdata", 64'(debug_wb_rf_wdata), 64'(mq[0].res));
        end
        h0 = 1'b0; h1 = 1'b0; d0 = '0; d1 = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!h0 && mq[i].we && q0_addr != '0 && mq[i].dest == q0_addr) begin
                h0 = 1'b1; d0 = mq[i].res;
            end
            if (!h1 && mq[i].we && q1_addr != '0 && mq[i].dest == q1_addr) begin
                h1 = 1'b1; d1 = mq[i].res;
            end
        end
        chk("q0_hit", 64'(q0_hit), 64'(h0));
        chk("q0_data", 64'(q0_data), 64'(d0));
        chk("q1_hit", 64'(q1_hit), 64'(h1));
        chk("q1_data", 64'(q1_data), 64'(d1));
    endtask

    // One clock: check at negedge, then advance the model across the posedge
    task automatic step();
        logic ret, acc;
        ent_t e;
        @(negedge clk);
        check_outputs();
        ret = 1'b0;
        if (mq.size() > 0) ret = !mq[0].we || rf_wready;
        acc = ms_to_ws_valid && (mq.size() < D);
        e.we = ms_gr_we; e.dest = ms_dest; e.res = ms_result; e.pc = ms_pc;
        @(posedge clk);
        #1;
        if (ret) void'(mq.pop_front());
        if (acc) mq.push_back(e);
    endtask

    task automatic offer(input logic v, input logic we, input logic [AW-1:0] dst,
                         input logic [DW-1:0] res, input logic [31:0] pc);
        ms_to_ws_valid = v; ms_gr_we = we; ms_dest = dst; ms_result = res; ms_pc = pc;
    endtask

    initial begin
        resetn = 1'b0;
        rf_wready = 1'b0;
        q0_addr = '0; q1_addr = '0;
        offer(1'b0, 1'b0, '0, '0, '0);
        #1;
        check_outputs();
        chk("reset_allowin", 64'(ws_allowin), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // Single writing entry retires with full debug strobe
        rf_wready = 1'b1;
        offer(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 32'hBFC00000);
        step();
        offer(1'b0, 1'b0, '0, '0, '0);
        #1;
        chk("s1_rf_we", 64'(rf_we), 64'd1);
        chk("s1_waddr", 64'(rf_waddr), 64'd3);
        chk("s1_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        chk("s1_wen", 64'(debug_wb_rf_wen), 64'hF);
        step();
        chk("s1_count_zero", 64'(ws_count), 64'd0);
        step();

        // Back-to-back fill with a stalled write port, then in-order drain
        rf_wready = 1'b0;
        for (int i = 0; i < D; i++) begin
            offer(1'b1, 1'b1, AW'(i + 1), DW'(32'h100 + i), 32'h1000 + 32'(4 * i));
            step();
        end
        chk("s2_full_allowin", 64'(ws_allowin), 64'd0);
        chk("s2_full_count", 64'(ws_count), 64'(D));
        repeat (3) step();
        offer(1'b0, 1'b0, '0, '0, '0);
        rf_wready = 1'b1;
        for (int i = 0; i < D; i++) begin
            #1;
            chk("s2_drain_order", 64'(rf_wdata), 64'(32'h100 + i));
            step();
        end
        step();

        // Youngest matching entry forwards; register 0 never hits
        rf_wready = 1'b0;
        q0_addr = 5'd7; q1_addr = 5'd0;
        offer(1'b1, 1'b1, 5'd7, 32'h1, 32'h2000);
        step();
        offer(1'b1, 1'b1, 5'd7, 32'h2, 32'h2004);
        step();
        offer(1'b1, 1'b1, 5'd0, 32'h3, 32'h2008);
        step();
        offer(1'b0, 1'b0, '0, '0, '0);
        #1;
        chk("s3_q0_hit", 64'(q0_hit), 64'd1);
        chk("s3_q0_data", 64'(q0_data), 64'h2);
        chk("s3_q1_hit", 64'(q1_hit), 64'd0);
        step();
        rf_wready = 1'b1;
        repeat (4) step();

        // Non-writing entry retires without the write port
        rf_wready = 1'b0;
        offer(1'b1, 1'b0, 5'd9, 32'h55, 32'h3000);
        step();
        offer(1'b0, 1'b0, '0, '0, '0);
        #1;
        chk("s4_rf_we", 64'(rf_we), 64'd0);
        chk("s4_wen", 64'(debug_wb_rf_wen), 64'd0);
        step();
        chk("s4_count", 64'(ws_count), 64'd0);

        // Full queue under continuous offer and retire; pointers wrap
        for (int i = 0; i < D; i++) begin
            offer(1'b1, 1'b1, AW'(i + 10), DW'(32'h400 + i), 32'h4000 + 32'(4 * i));
            step();
        end
        rf_wready = 1'b1;
        for (int i = 0; i < 3 * D + 3; i++) begin
            offer(1'b1, 1'b1, AW'(i % 8), DW'(32'h500 + i), 32'h5000 + 32'(4 * i));
            step();
            chk("s5_count_bound", 64'(ws_count <= CW'(D)), 64'd1);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            offer(1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), $urandom, $urandom);
            rf_wready = 1'($urandom);
            q0_addr = AW'($urandom_range(0, 7));
            q1_addr = AW'($urandom_range(0, 7));
            step();
        end

        // Asynchronous reset with entries queued
        rf_wready = 1'b0;
        q0_addr = 5'd4; q1_addr = 5'd5;
        offer(1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < D + 2; i++) step();
        rf_wready = 1'b1;
        offer(1'b1, 1'b1, 5'd4, 32'hA, 32'h6000);
        step();
        offer(1'b1, 1'b1, 5'd5, 32'hB, 32'h6004);
        step();
        offer(1'b1, 1'b1, 5'd6, 32'hC, 32'h6008);
        rf_wready = 1'b0;
        #2;
        resetn = 1'b0;
        mq.delete();
        #1;
        chk("rst_count", 64'(ws_count), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_wen", 64'(debug_wb_rf_wen), 64'd0);
        chk("rst_q0_hit", 64'(q0_hit), 64'd0);
        rf_wready = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        resetn = 1'b1;
        offer(1'b0, 1'b0, '0, '0, '0);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
